// File: rtl/aes_state_pkg.sv
// Shared AES state types, geometry constants and byte-addressing helpers.
package aes_state_pkg;

    localparam int unsigned AES_ROWS    = 4;
    localparam int unsigned AES_COLS    = 4;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned AES_STATE_W = AES_ROWS * AES_COLS * BYTE_W;

    typedef logic [AES_STATE_W-1:0] aes_state_t;

    // Column-major byte position of S[r][c]; byte 0 sits in the LSBs.
    function automatic int unsigned byte_idx(input int unsigned r, input int unsigned c);
        return AES_COLS * c + r;
    endfunction

    // Source column feeding output column c of row r.
    // Forward pulls from (c+r) mod 4, inverse pulls from (c-r) mod 4.
    function automatic int unsigned src_col(input int unsigned r, input int unsigned c,
                                            input bit inverse);
        if (inverse) begin
            return (c + AES_COLS - r) % AES_COLS;
        end
        return (c + r) % AES_COLS;
    endfunction

endpackage

// File: rtl/shift_rows_unit_if.sv
// Upstream/downstream ready/valid bundle for the ShiftRows stage.
interface shift_rows_unit_if;
    import aes_state_pkg::*;

    logic       in_valid;
    logic       in_ready;
    logic       inv;
    aes_state_t in_state;
    logic       out_valid;
    logic       out_ready;
    aes_state_t out_state;

    // Environment side: produces input transfers and consumes results.
    modport master (
        output in_valid,
        output inv,
        output in_state,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state
    );

    // Stage side.
    modport slave (
        input  in_valid,
        input  inv,
        input  in_state,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state
    );

endinterface

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows (INVERSE=0) or InvShiftRows (INVERSE=1) byte routing.
// Pure wiring; also usable standalone inside an encrypt round.
module shift_rows_perm
    import aes_state_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  aes_state_t in_state,
    output aes_state_t out_state
);

    // Gather each output byte from its source column within the same row.
    always_comb begin
        out_state = '0;
        for (int unsigned r = 0; r < AES_ROWS; r++) begin
            for (int unsigned c = 0; c < AES_COLS; c++) begin
                out_state[BYTE_W*byte_idx(r, c) +: BYTE_W] =
                    in_state[BYTE_W*byte_idx(r, src_col(r, c, INVERSE)) +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/shift_rows_unit.sv
// Registered ShiftRows/InvShiftRows stage with a single-entry ready/valid output.
module shift_rows_unit
    import aes_state_pkg::*;
#(
    parameter bit FWD_ONLY = 1'b0
) (
    input logic              clk,
    input logic              rst,
    shift_rows_unit_if.slave bus
);

    aes_state_t fwd_state_c;
    aes_state_t inv_state_c;
    aes_state_t perm_state_c;
    logic       inv_sel_c;
    logic       in_ready_c;
    logic       xfer_c;

    logic       out_valid_d, out_valid_q;
    aes_state_t out_state_d, out_state_q;

    shift_rows_perm #(.INVERSE(1'b0)) u_fwd (
        .in_state  (bus.in_state),
        .out_state (fwd_state_c)
    );

    if (FWD_ONLY) begin : g_fwd_only
        assign inv_state_c = fwd_state_c;
    end else begin : g_inv
        shift_rows_perm #(.INVERSE(1'b1)) u_inv (
            .in_state  (bus.in_state),
            .out_state (inv_state_c)
        );
    end

    // Direction select; forced forward when the inverse path is not built.
    always_comb begin
        inv_sel_c    = FWD_ONLY ? 1'b0 : bus.inv;
        perm_state_c = inv_sel_c ? inv_state_c : fwd_state_c;
    end

    // Accept when empty or when the held result drains this cycle.
    always_comb begin
        in_ready_c = !out_valid_q || bus.out_ready;
        xfer_c     = bus.in_valid && in_ready_c;
    end

    // Next-state for the output register: load on transfer, clear on drain.
    always_comb begin
        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
        if (xfer_c) begin
            out_valid_d = 1'b1;
            out_state_d = perm_state_c;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register; reset wins over a simultaneous transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_state_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = out_state_q;

endmodule

// File: tb/tb_shift_rows_unit.sv
// Directed bench for shift_rows_unit: known vectors, backpressure, reset, round trips.
module tb_shift_rows_unit;
    import aes_state_pkg::*;

    localparam aes_state_t FWD_IN  = 128'h33231303322212023121110130201000;
    localparam aes_state_t FWD_OUT = 128'h32211003312013023023120133221100;
    localparam aes_state_t SB_IN   = 128'h00000000000000000000FF0000000000;
    localparam aes_state_t SB_OUT  = 128'h0000000000000000000000000000FF00;
    localparam int unsigned N_VEC  = 16 * 256;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    aes_state_t orig [N_VEC];
    aes_state_t mid  [N_VEC];
    int unsigned sh;
    int unsigned val;
    int          e0;

    shift_rows_unit_if bus_if ();

    shift_rows_unit #(.FWD_ONLY(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Where a lone byte at position shift lands: forward moves it to column
    // (c-r) mod 4, inverse to column (c+r) mod 4, row unchanged.
    function automatic aes_state_t single_byte_dest(input int unsigned shift,
                                                    input int unsigned v, input bit inv_dir);
        int unsigned r;
        int unsigned c;
        int unsigned dc;
        r  = shift % 4;
        c  = shift / 4;
        dc = inv_dir ? (c + r) % 4 : (c + 4 - r) % 4;
        return aes_state_t'(v) << (8 * (4 * dc + r));
    endfunction

    task automatic drive(input logic v, input logic i, input aes_state_t s, input logic ordy);
        @(negedge clk);
        bus_if.in_valid  = v;
        bus_if.inv       = i;
        bus_if.in_state  = s;
        bus_if.out_ready = ordy;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.inv       = 1'b0;
        bus_if.in_state  = '0;
        bus_if.out_ready = 1'b0;
        after_edge();
        after_edge();
        check_eq("rst_valid", 128'(bus_if.out_valid), 128'(1'b0));
        check_eq("rst_state", bus_if.out_state, '0);
        check_eq("rst_ready", 128'(bus_if.in_ready), 128'(1'b1));
        @(negedge clk);
        rst = 1'b0;

        // Known vectors, one per cycle, downstream always ready.
        drive(1'b1, 1'b0, FWD_IN, 1'b1);
        after_edge();
        check_eq("fwd_valid", 128'(bus_if.out_valid), 128'(1'b1));
        check_eq("fwd_vec", bus_if.out_state, FWD_OUT);
        drive(1'b1, 1'b1, FWD_OUT, 1'b1);
        after_edge();
        check_eq("inv_vec", bus_if.out_state, FWD_IN);
        drive(1'b1, 1'b0, SB_IN, 1'b1);
        after_edge();
        check_eq("sb_fwd", bus_if.out_state, SB_OUT);
        drive(1'b1, 1'b1, SB_OUT, 1'b1);
        after_edge();
        check_eq("sb_inv", bus_if.out_state, SB_IN);
        drive(1'b0, 1'b0, '0, 1'b1);
        after_edge();
        check_eq("drain_valid", 128'(bus_if.out_valid), 128'(1'b0));

        // Backpressure: result held, new input refused until out_ready rises.
        drive(1'b1, 1'b0, FWD_IN, 1'b0);
        after_edge();
        check_eq("bp_load", bus_if.out_state, FWD_OUT);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, SB_IN, 1'b0);
            #1;
            check_eq("bp_ready", 128'(bus_if.in_ready), 128'(1'b0));
            after_edge();
            check_eq("bp_hold", bus_if.out_state, FWD_OUT);
            check_eq("bp_valid", 128'(bus_if.out_valid), 128'(1'b1));
        end
        drive(1'b1, 1'b1, FWD_OUT, 1'b1);
        #1;
        check_eq("bp_release_ready", 128'(bus_if.in_ready), 128'(1'b1));
        after_edge();
        check_eq("bp_new", bus_if.out_state, FWD_IN);
        check_eq("bp_new_valid", 128'(bus_if.out_valid), 128'(1'b1));
        drive(1'b0, 1'b0, '0, 1'b1);
        after_edge();
        check_eq("bp_consumed", 128'(bus_if.out_valid), 128'(1'b0));

        // Reset while holding a result with a pending input.
        drive(1'b1, 1'b0, FWD_IN, 1'b0);
        after_edge();
        check_eq("pre_rst_valid", 128'(bus_if.out_valid), 128'(1'b1));
        @(negedge clk);
        rst = 1'b1;
        bus_if.in_valid = 1'b1;
        bus_if.in_state = SB_IN;
        after_edge();
        check_eq("mid_rst_valid", 128'(bus_if.out_valid), 128'(1'b0));
        check_eq("mid_rst_state", bus_if.out_state, '0);
        check_eq("mid_rst_ready", 128'(bus_if.in_ready), 128'(1'b1));
        @(negedge clk);
        rst = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        after_edge();
        check_eq("rst_drop_valid", 128'(bus_if.out_valid), 128'(1'b0));
        check_eq("rst_drop_state", bus_if.out_state, '0);

        // Round trip forward then inverse, streamed back-to-back.
        for (int k = 0; k < N_VEC; k++) begin
            sh = k / 256;
            val = k % 256;
            orig[k] = aes_state_t'(val) << (8 * sh);
            drive(1'b1, 1'b0, orig[k], 1'b1);
            after_edge();
            mid[k] = bus_if.out_state;
            e0 = errors;
            check_eq("rt_fwd", mid[k], single_byte_dest(sh, val, 1'b0));
            if (errors != e0) break;
        end
        for (int k = 0; k < N_VEC; k++) begin
            drive(1'b1, 1'b1, mid[k], 1'b1);
            after_edge();
            e0 = errors;
            check_eq("rt_fwd_inv", bus_if.out_state, orig[k]);
            if (errors != e0) break;
        end

        // Round trip inverse then forward.
        for (int k = 0; k < N_VEC; k++) begin
            sh = k / 256;
            val = k % 256;
            drive(1'b1, 1'b1, orig[k], 1'b1);
            after_edge();
            mid[k] = bus_if.out_state;
            e0 = errors;
            check_eq("rt_inv", mid[k], single_byte_dest(sh, val, 1'b1));
            if (errors != e0) break;
        end
        for (int k = 0; k < N_VEC; k++) begin
            drive(1'b1, 1'b0, mid[k], 1'b1);
            after_edge();
            e0 = errors;
            check_eq("rt_inv_fwd", bus_if.out_state, orig[k]);
            if (errors != e0) break;
        end
        check_eq("stream_valid", 128'(bus_if.out_valid), 128'(1'b1));

        drive(1'b0, 1'b0, '0, 1'b1);
        after_edge();
        check_eq("final_drain", 128'(bus_if.out_valid), 128'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
